sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
//  Parametrised per-pixel renderer for the VGA game display: N_SPR rectangular sprites, fixed priority
//  (index 0 highest), play-area clip and background colour, composited into 4:4:4 RGB.
//  Pipelined on the 25 MHz pixel strobe, between the vga640x480 timing and the VGA pins.
//  Optionally accumulates per-frame overlap of sprite 0 (player) against every other sprite for game state.
// PARAMETERS
//  N_SPR    4    number of sprite channels, 2..16
//  XW       10   x coordinate width
//  YW       9    y coordinate width
//  AREA_L   20   play-area left edge, inclusive
//  AREA_R   620  play-area right edge, inclusive
//  AREA_T   20   play-area top edge, inclusive
//  AREA_B   460  play-area bottom edge, inclusive
// PORTS
//  clk_in        in   1          system clock (100 MHz)
//  reset_in      in   1          asynchronous, active-low reset
//  pix_stb       in   1          pixel strobe; pipeline advances only when it is high
//  x             in   XW         current pixel x
//  y             in   YW         current pixel y
//  active        in   1          pixel inside visible 640x480 window
//  frame_start   in   1          high for the strobe on which pixel (0,0) is presented
//  spr_en        in   N_SPR      per-sprite enable
//  spr_l/spr_r   in   N_SPR*XW   packed left/right bounds, inclusive; sprite i at [i*XW +: XW]
//  spr_t/spr_b   in   N_SPR*YW   packed top/bottom bounds, inclusive
//  spr_rgb       in   N_SPR*12   packed colour {R,G,B}, 4 bits each
//  bg_rgb        in   12         colour of in-area pixels hit by no sprite
//  red_o/green_o/blue_o out 4    VGA colour
//  hit_any       out  1          displayed pixel belongs to a sprite
//  hit_idx       out  4          index of winning sprite; 0 when hit_any=0
//  collide_mask  out  N_SPR      sprites overlapping sprite 0 in the previous frame; bit 0 always 0
//  collide_valid out  1          one-clk_in pulse when collide_mask updates
// BEHAVIOUR
//  - Reset (reset_in=0, async): every output 0; pipeline valid bits, accumulator and colour regs cleared.
//  - Stage 1 (pix_stb): hit[i] = spr_en[i] & l<=x<=r & t<=y<=b; in_area = active & x,y within AREA_*.
//    Sprite bounds and colours are sampled on the same strobe as x/y.
//  - Stage 2 (pix_stb): lowest set hit index wins. Colour = spr_rgb[win] if in_area&hit_any,
//    bg_rgb if in_area and no hit, 0 if !in_area. Sprites are clipped to the area.
//  - Latency: x/y on strobe k -> RGB valid after strobe k+2; outputs hold between strobes.
//  - hit_any/hit_idx are aligned with the RGB output; hit_idx zero-extended to 4 bits.
//  - l>r or t>b: empty sprite, never hits. Equal bounds: single pixel/line. No wrap-around of coordinates.
//  - pix_stb low: no stage updates, no accumulation; frame_start is ignored unless pix_stb is high.
//  - Reset mid-frame: pipeline flushes; the first two strobes after release output black.
// CONFIGURATION
//  SPRITE_COLLIDE_EN defined:
//  - On each stage-1 strobe with in_area & hit[0], acc[k] |= hit[k] for k>=1.
//  - On a strobe with frame_start: collide_mask <= acc (including that strobe's own contribution
//    ORed in), collide_valid=1 for one clk_in. acc then restarts from 0; the strobe's hits go to the old frame.
//  - Disabled sprite 0 produces no overlaps.
//  SPRITE_COLLIDE_EN undefined: no accumulator logic; collide_mask=0 and collide_valid=0 constantly.
// TESTING
//  1. Reset, N_SPR=4, sprite0 [100..109]x[200..209] red 12'hF00, others disabled, bg 12'h0A0.
//     Scan (105,205) -> RGB F,0,0 and hit_idx=0 two strobes later; (150,205) -> 0,A,0; (5,5) -> 0,0,0.
//  2. Sprites 1 and 2 both cover (300,300), rgb 12'h00F and 12'hFF0 -> output 0,0,F with hit_idx=1.
//     Disable sprite 1 -> FF0 with hit_idx=2.
//  3. Sprite0 l=r=50, t=b=50 -> only (50,50) hits. Sprite l=60,r=59 -> never hits.
//     Sprite spanning x 0..30 -> pixels x<20 are black.
//  4. (SPRITE_COLLIDE_EN) Sprite0 overlaps sprite3 for one frame, then frame_start ->
//     collide_mask=4'b1000 and collide_valid high exactly 1 clk. Next frame has no overlap -> 4'b0000.
//  5. Assert reset_in low mid-scan between strobes -> all outputs 0 immediately. After release,
//     the first 2 strobes give black and collide_mask stays 0.
//  6. Hold pix_stb low for 10 clks while changing x/y -> RGB, hit_idx and accumulator are unchanged.

Source files
------------

// File: rtl/sprite_compositor_if.sv
// Pixel-stream, sprite-table and VGA-output bundle for sprite_compositor.
interface sprite_compositor_if #(
  parameter int unsigned N_SPR = 4,
  parameter int unsigned XW    = 10,
  parameter int unsigned YW    = 9
);
  logic                  pix_stb;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic                  active;
  logic                  frame_start;
  logic [N_SPR-1:0]      spr_en;
  logic [N_SPR*XW-1:0]   spr_l;
  logic [N_SPR*XW-1:0]   spr_r;
  logic [N_SPR*YW-1:0]   spr_t;
  logic [N_SPR*YW-1:0]   spr_b;
  logic [N_SPR*12-1:0]   spr_rgb;
  logic [11:0]           bg_rgb;
  logic [3:0]            red_o;
  logic [3:0]            green_o;
  logic [3:0]            blue_o;
  logic                  hit_any;
  logic [3:0]            hit_idx;
  logic [N_SPR-1:0]      collide_mask;
  logic                  collide_valid;

  // Timing generator / game logic side
  modport master (
    output pix_stb, x, y, active, frame_start,
    output spr_en, spr_l, spr_r, spr_t, spr_b, spr_rgb, bg_rgb,
    input  red_o, green_o, blue_o, hit_any, hit_idx, collide_mask, collide_valid
  );

  // Compositor side
  modport slave (
    input  pix_stb, x, y, active, frame_start,
    input  spr_en, spr_l, spr_r, spr_t, spr_b, spr_rgb, bg_rgb,
    output red_o, green_o, blue_o, hit_any, hit_idx, collide_mask, collide_valid
  );
endinterface

// File: rtl/sprite_compositor.sv
// Per-pixel sprite compositor: N_SPR fixed-priority rectangles (index 0 wins),
// play-area clip and background fill, two-strobe pipeline to 4:4:4 RGB.
// Optional macro SPRITE_COLLIDE_EN adds per-frame overlap of sprite 0 vs others.
module sprite_compositor #(
  parameter int unsigned N_SPR  = 4,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9,
  parameter int unsigned AREA_L = 20,
  parameter int unsigned AREA_R = 620,
  parameter int unsigned AREA_T = 20,
  parameter int unsigned AREA_B = 460
) (
  input logic              clk_in,
  input logic              reset_in,
  sprite_compositor_if.slave bus
);

  localparam int unsigned CW = 12;
  localparam int unsigned IW = 4;

  localparam logic [XW-1:0] AL = XW'(AREA_L);
  localparam logic [XW-1:0] AR = XW'(AREA_R);
  localparam logic [YW-1:0] AT = YW'(AREA_T);
  localparam logic [YW-1:0] AB = YW'(AREA_B);

  logic [N_SPR-1:0]    hit_c;
  logic                in_area_c;

  logic [N_SPR-1:0]    hit_q;
  logic                in_area_q;
  logic [N_SPR*CW-1:0] rgb_q;
  logic [CW-1:0]       bg_q;
  logic                v1_q;

  logic [IW-1:0]       win_c;
  logic [CW-1:0]       spr_col_c;
  logic                any_c;
  logic [CW-1:0]       col_c;
  logic [IW-1:0]       idx_c;

  logic [CW-1:0]       col2_q;
  logic                any2_q;
  logic [IW-1:0]       idx2_q;
  logic                v2_q;

  logic [CW-1:0]       out_rgb_q;
  logic                out_any_q;
  logic [IW-1:0]       out_idx_q;

  // Stage-1 hit test of the presented pixel against every sprite and the play area
  always_comb begin
    hit_c = '0;
    for (int i = 0; i < N_SPR; i++) begin
      hit_c[i] = bus.spr_en[i]
              && (bus.x >= bus.spr_l[i*XW +: XW]) && (bus.x <= bus.spr_r[i*XW +: XW])
              && (bus.y >= bus.spr_t[i*YW +: YW]) && (bus.y <= bus.spr_b[i*YW +: YW]);
    end
    in_area_c = bus.active && (bus.x >= AL) && (bus.x <= AR)
                           && (bus.y >= AT) && (bus.y <= AB);
  end

  // Stage-1 register: hits plus colours sampled on the same strobe as x/y
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      hit_q     <= '0;
      in_area_q <= 1'b0;
      rgb_q     <= '0;
      bg_q      <= '0;
      v1_q      <= 1'b0;
    end else if (bus.pix_stb) begin
      hit_q     <= hit_c;
      in_area_q <= in_area_c;
      rgb_q     <= bus.spr_rgb;
      bg_q      <= bus.bg_rgb;
      v1_q      <= 1'b1;
    end
  end

  // Stage-2 priority pick (lowest index wins) and clip/background selection
  always_comb begin
    win_c     = '0;
    spr_col_c = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        win_c     = IW'(i);
        spr_col_c = rgb_q[i*CW +: CW];
      end
    end
    any_c = v1_q && in_area_q && (|hit_q);
    if (!(v1_q && in_area_q)) begin
      col_c = '0;
    end else if (any_c) begin
      col_c = spr_col_c;
    end else begin
      col_c = bg_q;
    end
    idx_c = any_c ? win_c : '0;
  end

  // Stage-2 register
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      col2_q <= '0;
      any2_q <= 1'b0;
      idx2_q <= '0;
      v2_q   <= 1'b0;
    end else if (bus.pix_stb) begin
      col2_q <= col_c;
      any2_q <= any_c;
      idx2_q <= idx_c;
      v2_q   <= v1_q;
    end
  end

  // Output register: black until the pipeline has refilled after reset
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      out_rgb_q <= '0;
      out_any_q <= 1'b0;
      out_idx_q <= '0;
    end else if (bus.pix_stb) begin
      out_rgb_q <= v2_q ? col2_q : '0;
      out_any_q <= v2_q && any2_q;
      out_idx_q <= v2_q ? idx2_q : '0;
    end
  end

  assign bus.red_o   = out_rgb_q[11:8];
  assign bus.green_o = out_rgb_q[7:4];
  assign bus.blue_o  = out_rgb_q[3:0];
  assign bus.hit_any = out_any_q;
  assign bus.hit_idx = out_idx_q;

`ifdef SPRITE_COLLIDE_EN
  logic [N_SPR-1:0] contrib_c;
  logic [N_SPR-1:0] acc_q;
  logic [N_SPR-1:0] mask_q;
  logic             cvalid_q;

  // Overlaps of sprite 0 seen on this strobe; bit 0 never set
  always_comb begin
    contrib_c = '0;
    if (in_area_c && hit_c[0]) begin
      contrib_c = hit_c & ~N_SPR'(1);
    end
  end

  // Per-frame accumulator; the frame_start strobe's own hits close the old frame
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      acc_q    <= '0;
      mask_q   <= '0;
      cvalid_q <= 1'b0;
    end else begin
      cvalid_q <= 1'b0;
      if (bus.pix_stb) begin
        if (bus.frame_start) begin
          mask_q   <= acc_q | contrib_c;
          cvalid_q <= 1'b1;
          acc_q    <= '0;
        end else begin
          acc_q <= acc_q | contrib_c;
        end
      end
    end
  end

  assign bus.collide_mask  = mask_q;
  assign bus.collide_valid = cvalid_q;
`else
  logic unused_frame_start;
  assign unused_frame_start  = bus.frame_start;
  assign bus.collide_mask    = '0;
  assign bus.collide_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor (N_SPR=4, default play area).
module tb_sprite_compositor;

`ifdef SPRITE_COLLIDE_EN
  localparam logic COLLIDE = 1'b1;
`else
  localparam logic COLLIDE = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sprite_compositor_if #(.N_SPR(4), .XW(10), .YW(9)) bus ();

  sprite_compositor #(.N_SPR(4), .XW(10), .YW(9)) dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (bus)
  );

  logic [11:0] rgb;
  assign rgb = {bus.red_o, bus.green_o, bus.blue_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_spr(input int i, input logic en, input int l, input int r,
                         input int t, input int b, input logic [11:0] col);
    bus.spr_en[i]           = en;
    bus.spr_l[i*10 +: 10]   = 10'(l);
    bus.spr_r[i*10 +: 10]   = 10'(r);
    bus.spr_t[i*9 +: 9]     = 9'(t);
    bus.spr_b[i*9 +: 9]     = 9'(b);
    bus.spr_rgb[i*12 +: 12] = col;
  endtask

  task automatic strobe_at(input int px, input int py, input logic act);
    @(negedge clk);
    bus.x           = 10'(px);
    bus.y           = 9'(py);
    bus.active      = act;
    bus.frame_start = 1'b0;
    bus.pix_stb     = 1'b1;
    @(negedge clk);
    bus.pix_stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Present one pixel then flush it to the output with two blank strobes
  task automatic render(input int px, input int py);
    strobe_at(px, py, (px < 640) && (py < 480));
    strobe_at(0, 0, 1'b0);
    strobe_at(0, 0, 1'b0);
  endtask

  task automatic frame_pulse(output logic v_on, output logic [3:0] m_on,
                             output logic v_after, output logic [3:0] m_after);
    @(negedge clk);
    bus.x = '0; bus.y = '0; bus.active = 1'b1;
    bus.frame_start = 1'b1; bus.pix_stb = 1'b1;
    @(negedge clk);
    v_on = bus.collide_valid; m_on = bus.collide_mask;
    bus.pix_stb = 1'b0; bus.frame_start = 1'b0; bus.active = 1'b0;
    @(negedge clk);
    v_after = bus.collide_valid; m_after = bus.collide_mask;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", rgb); end
    checks++; if (bus.hit_any !== 1'b0) begin errors++; $display("FAIL reset_hit_any got %b want 0", bus.hit_any); end
    checks++; if (bus.hit_idx !== 4'd0) begin errors++; $display("FAIL reset_hit_idx got %0d want 0", bus.hit_idx); end
    checks++; if (bus.collide_mask !== 4'b0000) begin errors++; $display("FAIL reset_mask got %b want 0000", bus.collide_mask); end
    checks++; if (bus.collide_valid !== 1'b0) begin errors++; $display("FAIL reset_cvalid got %b want 0", bus.collide_valid); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    set_spr(0, 1'b1, 100, 109, 200, 209, 12'hF00);
    set_spr(1, 1'b0, 0, 0, 0, 0, 12'h000);
    set_spr(2, 1'b0, 0, 0, 0, 0, 12'h000);
    set_spr(3, 1'b0, 0, 0, 0, 0, 12'h000);
    bus.bg_rgb = 12'h0A0;
    render(105, 205);
    checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL basic_spr_rgb got %h want F00", rgb); end
    checks++; if (bus.hit_any !== 1'b1 || bus.hit_idx !== 4'd0) begin errors++; $display("FAIL basic_spr_hit got %b/%0d want 1/0", bus.hit_any, bus.hit_idx); end
    render(150, 205);
    checks++; if (rgb !== 12'h0A0) begin errors++; $display("FAIL basic_bg_rgb got %h want 0A0", rgb); end
    checks++; if (bus.hit_any !== 1'b0 || bus.hit_idx !== 4'd0) begin errors++; $display("FAIL basic_bg_hit got %b/%0d want 0/0", bus.hit_any, bus.hit_idx); end
    render(5, 5);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL basic_clip_rgb got %h want 000", rgb); end
    // latency: one strobe after presentation the output still shows the old black pixel
    strobe_at(105, 205, 1'b1);
    strobe_at(0, 0, 1'b0);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL latency_early got %h want 000", rgb); end
    strobe_at(0, 0, 1'b0);
    checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL latency_k2 got %h want F00", rgb); end
  endtask

  task automatic test_priority();
    set_spr(1, 1'b1, 290, 310, 290, 310, 12'h00F);
    set_spr(2, 1'b1, 295, 305, 295, 305, 12'hFF0);
    render(300, 300);
    checks++; if (rgb !== 12'h00F) begin errors++; $display("FAIL prio_rgb got %h want 00F", rgb); end
    checks++; if (bus.hit_any !== 1'b1 || bus.hit_idx !== 4'd1) begin errors++; $display("FAIL prio_idx got %b/%0d want 1/1", bus.hit_any, bus.hit_idx); end
    bus.spr_en[1] = 1'b0;
    render(300, 300);
    checks++; if (rgb !== 12'hFF0) begin errors++; $display("FAIL prio_dis_rgb got %h want FF0", rgb); end
    checks++; if (bus.hit_idx !== 4'd2) begin errors++; $display("FAIL prio_dis_idx got %0d want 2", bus.hit_idx); end
  endtask

  task automatic test_bounds();
    set_spr(0, 1'b1, 50, 50, 50, 50, 12'hF00);
    set_spr(1, 1'b1, 60, 59, 40, 60, 12'h00F);
    set_spr(2, 1'b1, 0, 30, 90, 110, 12'hFF0);
    set_spr(3, 1'b1, 615, 630, 100, 100, 12'h0FF);
    render(50, 50);
    checks++; if (rgb !== 12'hF00 || bus.hit_idx !== 4'd0) begin errors++; $display("FAIL single_px got %h/%0d want F00/0", rgb, bus.hit_idx); end
    render(51, 50);
    checks++; if (rgb !== 12'h0A0) begin errors++; $display("FAIL single_px_x1 got %h want 0A0", rgb); end
    render(50, 51);
    checks++; if (rgb !== 12'h0A0) begin errors++; $display("FAIL single_px_y1 got %h want 0A0", rgb); end
    render(60, 50);
    checks++; if (rgb !== 12'h0A0 || bus.hit_any !== 1'b0) begin errors++; $display("FAIL empty_l got %h/%b want 0A0/0", rgb, bus.hit_any); end
    render(59, 50);
    checks++; if (rgb !== 12'h0A0 || bus.hit_any !== 1'b0) begin errors++; $display("FAIL empty_r got %h/%b want 0A0/0", rgb, bus.hit_any); end
    render(10, 100);
    checks++; if (rgb !== 12'h000 || bus.hit_any !== 1'b0) begin errors++; $display("FAIL clip_left got %h/%b want 000/0", rgb, bus.hit_any); end
    render(19, 100);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL clip_x19 got %h want 000", rgb); end
    render(20, 100);
    checks++; if (rgb !== 12'hFF0 || bus.hit_idx !== 4'd2) begin errors++; $display("FAIL area_x20 got %h/%0d want FF0/2", rgb, bus.hit_idx); end
    render(620, 100);
    checks++; if (rgb !== 12'h0FF || bus.hit_idx !== 4'd3) begin errors++; $display("FAIL area_x620 got %h/%0d want 0FF/3", rgb, bus.hit_idx); end
    render(621, 100);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL clip_x621 got %h want 000", rgb); end
  endtask

  task automatic test_collide();
    logic v_on, v_after;
    logic [3:0] m_on, m_after;
    set_spr(0, 1'b1, 100, 109, 200, 209, 12'hF00);
    set_spr(1, 1'b0, 0, 0, 0, 0, 12'h000);
    set_spr(2, 1'b0, 0, 0, 0, 0, 12'h000);
    set_spr(3, 1'b1, 105, 120, 200, 209, 12'h0FF);
    frame_pulse(v_on, m_on, v_after, m_after);
    render(105, 205);
    frame_pulse(v_on, m_on, v_after, m_after);
    checks++; if (m_on !== 4'b1000) begin errors++; $display("FAIL collide_mask got %b want 1000", m_on); end
    checks++; if (v_on !== 1'b1) begin errors++; $display("FAIL collide_valid_on got %b want 1", v_on); end
    checks++; if (v_after !== 1'b0) begin errors++; $display("FAIL collide_valid_off got %b want 0", v_after); end
    checks++; if (m_after !== 4'b1000) begin errors++; $display("FAIL collide_mask_hold got %b want 1000", m_after); end
    render(101, 205);
    frame_pulse(v_on, m_on, v_after, m_after);
    checks++; if (m_on !== 4'b0000 || v_on !== 1'b1) begin errors++; $display("FAIL collide_clear got %b/%b want 0000/1", m_on, v_on); end
  endtask

  task automatic test_hold();
    logic v_on, v_after;
    logic [3:0] m_on, m_after;
    set_spr(0, 1'b1, 100, 109, 200, 209, 12'hF00);
    set_spr(3, 1'b1, 105, 120, 200, 209, 12'h0FF);
    frame_pulse(v_on, m_on, v_after, m_after);
    render(101, 205);
    checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL hold_pre got %h want F00", rgb); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.pix_stb = 1'b0;
      bus.x = 10'(105 + i);
      bus.y = 9'd205;
      bus.active = 1'b1;
      bus.frame_start = (i == 5);
    end
    @(negedge clk);
    bus.frame_start = 1'b0;
    checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL hold_rgb got %h want F00", rgb); end
    checks++; if (bus.hit_any !== 1'b1 || bus.hit_idx !== 4'd0) begin errors++; $display("FAIL hold_hit got %b/%0d want 1/0", bus.hit_any, bus.hit_idx); end
    checks++; if (bus.collide_valid !== 1'b0) begin errors++; $display("FAIL hold_no_pulse got %b want 0", bus.collide_valid); end
    frame_pulse(v_on, m_on, v_after, m_after);
    checks++; if (m_on !== 4'b0000) begin errors++; $display("FAIL hold_acc got %b want 0000", m_on); end
    checks++; if (v_on !== COLLIDE) begin errors++; $display("FAIL hold_cvalid got %b want %b", v_on, COLLIDE); end
  endtask

  task automatic test_reset_mid();
    logic v_on, v_after;
    logic [3:0] m_on, m_after;
    render(105, 205);
    checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL mid_pre got %h want F00", rgb); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (rgb !== 12'h000 || bus.hit_any !== 1'b0 || bus.hit_idx !== 4'd0) begin errors++; $display("FAIL mid_async got %h/%b/%0d want 000/0/0", rgb, bus.hit_any, bus.hit_idx); end
    checks++; if (bus.collide_mask !== 4'b0000) begin errors++; $display("FAIL mid_mask got %b want 0000", bus.collide_mask); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.spr_en[3] = 1'b0;
    strobe_at(105, 205, 1'b1);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL mid_s1 got %h want 000", rgb); end
    strobe_at(105, 205, 1'b1);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL mid_s2 got %h want 000", rgb); end
    strobe_at(105, 205, 1'b1);
    checks++; if (rgb !== 12'hF00 || bus.hit_any !== 1'b1) begin errors++; $display("FAIL mid_s3 got %h/%b want F00/1", rgb, bus.hit_any); end
    frame_pulse(v_on, m_on, v_after, m_after);
    checks++; if (m_on !== 4'b0000) begin errors++; $display("FAIL mid_acc got %b want 0000", m_on); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.pix_stb = 1'b0; bus.x = '0; bus.y = '0; bus.active = 1'b0; bus.frame_start = 1'b0;
    bus.spr_en = '0; bus.spr_l = '0; bus.spr_r = '0; bus.spr_t = '0; bus.spr_b = '0;
    bus.spr_rgb = '0; bus.bg_rgb = '0;
    test_reset();
    test_basic();
    test_priority();
    test_bounds();
`ifdef SPRITE_COLLIDE_EN
    test_collide();
`endif
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
